decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised instruction queue between the fetch register and the decoder. It is the multi-slot successor of the single-instruction fetch-to-decode hand-off. It accepts up to IN_W fetched {pc, raw_instr} pairs per cycle and presents up to OUT_W of the oldest to the decode slots in program order. Decode consumes a variable number of them each cycle, and a redirect from the pcselect/hazard path flushes the whole queue.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, at least max(IN_W, OUT_W)
- IN_W, 2, fetch slots accepted per cycle (1..4)
- OUT_W, 2, decode slots presented per cycle (1..4)
- XLEN, 64, pc width
- ILEN, 32, raw instruction width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- in_valid  in  IN_W  per-slot valid; set bits are contiguous from bit 0
- in_pc  in  IN_W*XLEN  slot i at bits [i*XLEN +: XLEN]
- in_instr  in  IN_W*ILEN  slot i at bits [i*ILEN +: ILEN]
- in_ready  out  1  queue can take a full IN_W group this cycle
- out_valid  out  OUT_W  per-slot valid, contiguous from bit 0
- out_pc  out  OUT_W*XLEN  slot 0 is the oldest entry
- out_instr  out  OUT_W*ILEN
- out_take  in  $clog2(OUT_W+1)  number of presented slots consumed this cycle
- flush  in  1  redirect: discard all contents
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry register array with head and tail pointers of $clog2(DEPTH)+1 bits. The extra bit separates the full case from the empty case. Index is pointer mod DEPTH, and the wrap is natural binary overflow.
- Push: when in_ready=1, the popcount of in_valid entries is written at tail, tail+1, … in slot order, and tail advances by that popcount. When in_ready=0, the inputs are ignored. Fetch must hold its inputs.
- in_ready = (DEPTH − count) ≥ IN_W. The term uses the registered count only. Pops in the same cycle do not credit space.
- Present: out_valid[j] = (j < count). out_pc[j] and out_instr[j] come from entry head+j mod DEPTH. Slots that are not valid drive 0.
- Pop: head advances by out_take. out_take greater than the number of valid out slots is illegal. The design asserts on it in simulation and saturates to that number in RTL.
- Same-cycle push and pop both apply: count_next = count + pushed − out_take.
- Flush has priority over push and pop in the same cycle:
  - head, tail and count return to 0;
  - the pushed group is discarded;
  - the group presented on the next cycle comes from fetch at the redirect target.
- Entry contents are not cleared on flush or pop. Only the pointers move.
- Reset is asynchronous and active-low. While reset=0, all of the following hold and are held:
  - head = tail = 0, count = 0;
  - out_valid = 0, out_pc = 0, out_instr = 0;
  - in_ready = 1.
- Deassertion of reset takes effect on the next clk edge.

## Timing
- Push-to-present latency is 1 cycle. An entry pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- The out_* path is first-word fall-through from registers, with a combinational mux only. There is no path from in_* to out_* within a cycle.
- in_ready depends on registered state only. There is no combinational path from out_take or flush to in_ready.
- count, head and tail are registered and update on every edge.
- Full (count=DEPTH): in_ready=0 and all OUT_W slots are valid.
- Empty (count=0): out_valid=0 and out_take must be 0.
- Reset asserted mid-operation clears the queue within the same cycle (asynchronous). No partial group survives.

## Test plan
- Reset sequence: reset=0 with garbage on the inputs → count=0, out_valid=0, in_ready=1. After release, push pc 0x80000000/0x80000004 with in_valid=2'b11 → next cycle out_valid=2'b11, out_pc[0]=0x80000000, out_pc[1]=0x80000004, count=2.
- Fill to full with DEPTH=8, IN_W=2, out_take=0 → after 4 pushes, count=8, in_ready=0. A 5th group held on the inputs is not written. Then out_take=2 → count=6, and in_ready=1 on the following cycle.
- Wrap-around: push and pop continuously 2/cycle for 20 cycles with incrementing pc. The out_pc sequence is strictly +4 with no gaps or duplicates across the pointer wrap at entry 7→0.
- Partial take and partial push: count=3, in_valid=2'b01, out_take=1 → count=3, and the new slot 0 is the former slot 1. Then out_take=2 and in_valid=0 → count=1.
- Flush with simultaneous push and pop: count=5, in_valid=2'b11, out_take=2, flush=1 → next cycle count=0, out_valid=0. The following push of target 0x80001000 appears on slot 0.
- Async reset mid-stream: assert reset between edges while count=6 → count=0 and out_valid=0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/decode_queue.sv
// Purpose: multi-slot instruction queue between fetch and decode; keeps program order.
// Latency: one cycle from push to present; out_* are registers followed by a read mux only.
// Backpressure: in_ready drops unless a full IN_W group fits; pops do not credit space the same cycle.
//
// Ports:
//   clk, reset           rising-edge clock; asynchronous active-low reset
//   in_valid/pc/instr    up to IN_W fetched {pc, instr} pairs, valid bits contiguous from slot 0
//   in_ready             a whole IN_W group can be accepted this cycle
//   out_valid/pc/instr   up to OUT_W oldest entries, slot 0 oldest; invalid slots drive 0
//   out_take             number of presented slots decode consumes this cycle
//   flush                redirect: drop everything, including this cycle's push and pop
//   count                current occupancy
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_W-1:0]              in_valid,
  input  logic [IN_W*XLEN-1:0]         in_pc,
  input  logic [IN_W*ILEN-1:0]         in_instr,
  output logic                         in_ready,
  output logic [OUT_W-1:0]             out_valid,
  output logic [OUT_W*XLEN-1:0]        out_pc,
  output logic [OUT_W*ILEN-1:0]        out_instr,
  input  logic [$clog2(OUT_W+1)-1:0]   out_take,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TAKE_W = $clog2(OUT_W + 1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [XLEN-1:0]   pc_mem_q    [DEPTH];
  logic [XLEN-1:0]   pc_mem_d    [DEPTH];
  logic [ILEN-1:0]   instr_mem_q [DEPTH];
  logic [ILEN-1:0]   instr_mem_d [DEPTH];

  logic              push_en;
  logic [CNT_W-1:0]  pushed;
  logic [TAKE_W-1:0] n_vld;
  logic [TAKE_W-1:0] take_eff;
  logic [IDX_W-1:0]  rd_idx;

  // Space check uses the registered count only, so out_take and flush never reach in_ready.
  assign in_ready = (DEPTH - int'(count_q)) >= IN_W;
  assign count    = count_q;

  // Number of slots actually presented; out_take beyond this is clamped.
  always_comb begin
    if (int'(count_q) >= OUT_W) n_vld = TAKE_W'(OUT_W);
    else                        n_vld = TAKE_W'(count_q);
    take_eff = (out_take > n_vld) ? n_vld : out_take;
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    push_en     = in_ready && !flush;
    pushed      = '0;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    for (int i = 0; i < IN_W; i++) begin
      if (push_en && in_valid[i]) begin
        pc_mem_d[tail_q[IDX_W-1:0] + IDX_W'(i)]    = in_pc[i*XLEN +: XLEN];
        instr_mem_d[tail_q[IDX_W-1:0] + IDX_W'(i)] = in_instr[i*ILEN +: ILEN];
        pushed = pushed + CNT_W'(1);
      end
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(take_eff);
      tail_d  = tail_q + PTR_W'(pushed);
      count_d = count_q + pushed - CNT_W'(take_eff);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents are never cleared; only the pointers decide what is live.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  // Present the oldest entries; invalid slots are forced to zero.
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_instr = '0;
    rd_idx    = '0;
    for (int j = 0; j < OUT_W; j++) begin
      rd_idx = head_q[IDX_W-1:0] + IDX_W'(j);
      if (int'(count_q) > j) begin
        out_valid[j]                = 1'b1;
        out_pc[j*XLEN +: XLEN]      = pc_mem_q[rd_idx];
        out_instr[j*ILEN +: ILEN]   = instr_mem_q[rd_idx];
      end
    end
  end

  // Decode must never consume more than is presented.
  a_take_legal: assert property (@(posedge clk) disable iff (!reset) out_take <= n_vld);
  // Occupancy register and pointer distance must always agree.
  a_count_ptr: assert property (@(posedge clk) disable iff (!reset)
                                count_q == CNT_W'(tail_q - head_q));

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  localparam int DEPTH = 8;
  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic                      clk;
  logic                      reset;
  logic [IN_W-1:0]           in_valid;
  logic [IN_W*XLEN-1:0]      in_pc;
  logic [IN_W*ILEN-1:0]      in_instr;
  logic                      in_ready;
  logic [OUT_W-1:0]          out_valid;
  logic [OUT_W*XLEN-1:0]     out_pc;
  logic [OUT_W*ILEN-1:0]     out_instr;
  logic [1:0]                out_take;
  logic                      flush;
  logic [3:0]                count;

  int checks = 0;
  int errors = 0;

  decode_queue #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_take(out_take), .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=running exp=done");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  v;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic [1:0]  take;
    logic        fl;
    logic [3:0]  cnt;
    logic [1:0]  ov;
    logic [63:0] e0;
    logic [63:0] e1;
    logic        rdy;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [1:0] take, input logic fl);
    in_valid = v;
    in_pc    = {p1, p0};
    in_instr = {instr_of(p1), instr_of(p0)};
    out_take = take;
    flush    = fl;
  endtask

  task automatic check_out(input string tag, input logic [3:0] cnt, input logic [1:0] ov,
                           input logic [63:0] e0, input logic [63:0] e1, input logic rdy);
    chk({tag, " count"},     64'(count), 64'(cnt));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag, " out_pc0"},   out_pc[63:0], e0);
    chk({tag, " out_pc1"},   out_pc[127:64], e1);
    chk({tag, " out_instr0"}, 64'(out_instr[31:0]),  ov[0] ? 64'(instr_of(e0)) : 64'd0);
    chk({tag, " out_instr1"}, 64'(out_instr[63:32]), ov[1] ? 64'(instr_of(e1)) : 64'd0);
    chk({tag, " in_ready"},  64'(in_ready), 64'(rdy));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] nxt;

  initial begin
    // v, pc0, pc1, take, flush | count, out_valid, pc0, pc1, in_ready
    vecs[0]  = '{2'b11, B+'h00, B+'h04, 2'd0, 1'b0, 4'd2, 2'b11, B+'h00, B+'h04, 1'b1};
    vecs[1]  = '{2'b11, B+'h08, B+'h0C, 2'd0, 1'b0, 4'd4, 2'b11, B+'h00, B+'h04, 1'b1};
    vecs[2]  = '{2'b11, B+'h10, B+'h14, 2'd0, 1'b0, 4'd6, 2'b11, B+'h00, B+'h04, 1'b1};
    vecs[3]  = '{2'b11, B+'h18, B+'h1C, 2'd0, 1'b0, 4'd8, 2'b11, B+'h00, B+'h04, 1'b0};
    vecs[4]  = '{2'b11, B+'h20, B+'h24, 2'd0, 1'b0, 4'd8, 2'b11, B+'h00, B+'h04, 1'b0};
    vecs[5]  = '{2'b11, B+'h20, B+'h24, 2'd2, 1'b0, 4'd6, 2'b11, B+'h08, B+'h0C, 1'b1};
    vecs[6]  = '{2'b11, B+'h20, B+'h24, 2'd2, 1'b0, 4'd6, 2'b11, B+'h10, B+'h14, 1'b1};
    vecs[7]  = '{2'b00, 64'd0,  64'd0,  2'd2, 1'b0, 4'd4, 2'b11, B+'h18, B+'h1C, 1'b1};
    vecs[8]  = '{2'b00, 64'd0,  64'd0,  2'd2, 1'b0, 4'd2, 2'b11, B+'h20, B+'h24, 1'b1};
    vecs[9]  = '{2'b00, 64'd0,  64'd0,  2'd1, 1'b0, 4'd1, 2'b01, B+'h24, 64'd0,  1'b1};
    vecs[10] = '{2'b01, B+'h28, 64'd0,  2'd0, 1'b0, 4'd2, 2'b11, B+'h24, B+'h28, 1'b1};
    vecs[11] = '{2'b00, 64'd0,  64'd0,  2'd1, 1'b0, 4'd1, 2'b01, B+'h28, 64'd0,  1'b1};
    vecs[12] = '{2'b11, B+'h2C, B+'h30, 2'd0, 1'b0, 4'd3, 2'b11, B+'h28, B+'h2C, 1'b1};
    vecs[13] = '{2'b01, B+'h34, 64'd0,  2'd1, 1'b0, 4'd3, 2'b11, B+'h2C, B+'h30, 1'b1};
    vecs[14] = '{2'b00, 64'd0,  64'd0,  2'd2, 1'b0, 4'd1, 2'b01, B+'h34, 64'd0,  1'b1};
    vecs[15] = '{2'b11, B+'h38, B+'h3C, 2'd0, 1'b0, 4'd3, 2'b11, B+'h34, B+'h38, 1'b1};
    vecs[16] = '{2'b11, B+'h40, B+'h44, 2'd0, 1'b0, 4'd5, 2'b11, B+'h34, B+'h38, 1'b1};
    vecs[17] = '{2'b11, B+'h48, B+'h4C, 2'd2, 1'b1, 4'd0, 2'b00, 64'd0,  64'd0,  1'b1};
    vecs[18] = '{2'b11, B+'h1000, B+'h1004, 2'd0, 1'b0, 4'd2, 2'b11, B+'h1000, B+'h1004, 1'b1};
    vecs[19] = '{2'b00, 64'd0,  64'd0,  2'd2, 1'b0, 4'd0, 2'b00, 64'd0,  64'd0,  1'b1};

    // Reset held with garbage on the inputs, across clock edges.
    reset = 1'b0;
    drive(2'b11, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002, 2'd3, 1'b0);
    step;
    step;
    check_out("reset", 4'd0, 2'b00, 64'd0, 64'd0, 1'b1);

    drive(2'b00, 64'd0, 64'd0, 2'd0, 1'b0);
    reset = 1'b1;

    // Table: fill, full hold-off, drain, partial take/push, flush.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v, vecs[i].pc0, vecs[i].pc1, vecs[i].take, vecs[i].fl);
      step;
      check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].e0, vecs[i].e1,
                vecs[i].rdy);
    end

    // Streaming 2 in / 2 out per cycle across several pointer wraps.
    nxt = B + 64'h2000;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        chk($sformatf("wrap%0d pc0", k), out_pc[63:0], nxt);
        chk($sformatf("wrap%0d pc1", k), out_pc[127:64], nxt + 64'd4);
        nxt = nxt + 64'd8;
      end
      drive(2'b11, B + 64'h2000 + 64'(k*8), B + 64'h2004 + 64'(k*8), (k > 0) ? 2'd2 : 2'd0, 1'b0);
      step;
      chk($sformatf("wrap%0d count", k), 64'(count), 64'd2);
    end
    chk("wrap last pc0", out_pc[63:0], nxt);
    drive(2'b00, 64'd0, 64'd0, 2'd2, 1'b0);
    step;
    check_out("drain", 4'd0, 2'b00, 64'd0, 64'd0, 1'b1);

    // Asynchronous reset in the middle of a cycle with six entries live.
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, B + 64'h3000 + 64'(k*8), B + 64'h3004 + 64'(k*8), 2'd0, 1'b0);
      step;
    end
    drive(2'b00, 64'd0, 64'd0, 2'd0, 1'b0);
    check_out("pre_arst", 4'd6, 2'b11, B + 64'h3000, B + 64'h3004, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_out("arst", 4'd0, 2'b00, 64'd0, 64'd0, 1'b1);
    step;
    reset = 1'b1;
    drive(2'b11, B + 64'h4000, B + 64'h4004, 2'd0, 1'b0);
    step;
    check_out("post_arst", 4'd2, 2'b11, B + 64'h4000, B + 64'h4004, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
